// File: rtl/apb_regfile_pkg.sv
// Shared definitions for the APB register file: FSM state encoding and response codes.
package apb_regfile_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } apb_state_e;

  localparam logic RespOkay = 1'b0;
  localparam logic RespErr  = 1'b1;

endpackage

// File: rtl/apb_regfile_if.sv
// APB bus bundle between a bridge (master) and the register file (slave).
interface apb_regfile_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);

  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                pwrite;
  logic                psel;
  logic                penable;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    output addr, pwdata, pstrb, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  addr, pwdata, pstrb, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter for APB wait states; zero flags the end of the wait.
module apb_wait_ctr #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_regfile.sv
// Parametrised APB slave register bank with byte strobes, wait states, slave error on
// out-of-range addresses and a sticky protocol-violation flag.
module apb_regfile
  import apb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  apb_regfile_if.slave    bus,
  output logic            proto_err,
  input  logic            err_clr
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WaitVal = CNT_W'(WAIT_CYCLES);

  apb_state_e           state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_W-1:0]    pwdata_q;
  logic [NBYTES-1:0]    pstrb_q;
  logic                 pwrite_q;
  logic                 err_q;
  logic [DATA_W-1:0]    prdata_q;
  logic                 proto_err_q;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic in_access, cnt_zero, pready, setup, complete, commit;
  logic viol_idle, viol_abort, proto_viol, addr_err;

  always_comb begin
    in_access  = (state_q == StAccess);
    pready     = in_access && cnt_zero;
    // A new SETUP is accepted from IDLE or in the final ACCESS cycle (back-to-back).
    setup      = bus.psel && !bus.penable && (!in_access || pready);
    complete   = in_access && pready && bus.psel && bus.penable;
    commit     = complete && pwrite_q && !err_q;
    viol_idle  = !in_access && bus.psel && bus.penable;
    viol_abort = in_access && !pready && !(bus.psel && bus.penable);
    proto_viol = viol_idle || viol_abort;
    addr_err   = 32'(bus.addr) >= DEPTH;
  end

  apb_wait_ctr #(
    .CNT_W(CNT_W)
  ) u_wait_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (setup),
    .load_val(WaitVal),
    .dec     (in_access),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pwrite_q    <= 1'b0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // A violation in the same cycle as err_clr keeps the flag set.
      proto_err_q <= proto_viol || (proto_err_q && !err_clr);

      if (setup) begin
        idx_q    <= bus.addr[IDX_W-1:0];
        pwdata_q <= bus.pwdata;
        pstrb_q  <= bus.pstrb;
        pwrite_q <= bus.pwrite;
        err_q    <= addr_err;
        if (!bus.pwrite) begin
          prdata_q <= addr_err ? '0 : mem_q[bus.addr[IDX_W-1:0]];
        end
      end

      if (commit) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (pstrb_q[b]) begin
            mem_q[idx_q][b*8 +: 8] <= pwdata_q[b*8 +: 8];
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (setup) state_q <= StAccess;
        end
        StAccess: begin
          if (setup) begin
            state_q <= StAccess;
          end else if (pready || viol_abort) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready;
  assign bus.pslverr = (pready && err_q) ? RespErr : RespOkay;
  assign proto_err   = proto_err_q;

endmodule
